clock_divider_ctrl: RTL and testbench

Runtime-programmable controller for the board's derived link clock. It owns the divide counter fed from the 50 MHz reference and produces the derived clock, a period tick and a period count. It accepts new divide/duty settings through a valid/ready handshake and applies them only on period boundaries, so the output never glitches. Out of reset it reproduces the existing 10 MHz, 40 % duty clock.

---
 rtl/clock_divider_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_divider_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - runtime-programmable glitch-free derived clock generator
//
// Purpose: divides FiftyMHz_ref_clock by a programmable ratio with a programmable
// high time. New settings arrive over a valid/ready handshake and take effect only
// on period boundaries. Defaults reproduce a 10 MHz, 40 % duty clock.
//
// Ports:
//   FiftyMHz_ref_clock  in   reference clock, all logic on rising edge
//   reset_n             in   asynchronous active-low reset
//   run_en              in   1 = generate clock, 0 = stop at next period end
//   cfg_div             in   requested period in reference cycles
//   cfg_high            in   requested high cycles per period
//   cfg_valid           in   config offer
//   cfg_ready           out  config accepted when cfg_valid & cfg_ready
//   cfg_err             out  one-cycle pulse after an illegal config handshake
//   clk_out             out  registered derived clock
//   tick                out  high in the first reference cycle of each period
//   period_count        out  completed periods since reset (wraps)
//   running             out  1 while generating or finishing the last period

module clock_divider_ctrl #(
    parameter int DIV_WIDTH    = 8,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic                 FiftyMHz_ref_clock,
    input  logic                 reset_n,
    input  logic                 run_en,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [DIV_WIDTH-1:0] cfg_high,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 clk_out,
    output logic                 tick,
    output logic [15:0]          period_count,
    output logic                 running
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_a;
    logic [DIV_WIDTH-1:0] r_high_a;
    logic [DIV_WIDTH-1:0] r_div_p;
    logic [DIV_WIDTH-1:0] r_high_p;
    logic                 r_pend;
    logic [15:0]          r_period_count;
    logic                 r_clk_out;
    logic                 r_tick;
    logic                 r_cfg_err;

    logic [1:0]           w_state_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_div_a_nxt;
    logic [DIV_WIDTH-1:0] w_high_a_nxt;
    logic [DIV_WIDTH-1:0] w_div_p_nxt;
    logic [DIV_WIDTH-1:0] w_high_p_nxt;
    logic                 w_pend_nxt;
    logic [15:0]          w_period_count_nxt;
    logic                 w_cfg_err_nxt;
    logic                 w_clk_out_nxt;
    logic                 w_tick_nxt;
    logic                 w_run_nxt;

    logic                 w_cfg_fire;
    logic                 w_cfg_legal;
    logic                 w_wrap;

    assign w_cfg_fire  = cfg_valid & ~r_pend;
    assign w_cfg_legal = (cfg_div >= DIV_WIDTH'(2)) && (cfg_high >= DIV_WIDTH'(1))
                         && (cfg_high < cfg_div);
    // div_a is always >= 2, so div_a-1 never underflows
    assign w_wrap      = (r_state != S_IDLE) && (r_cnt == r_div_a - DIV_WIDTH'(1));

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_div_a_nxt        = r_div_a;
        w_high_a_nxt       = r_high_a;
        w_div_p_nxt        = r_div_p;
        w_high_p_nxt       = r_high_p;
        w_pend_nxt         = r_pend;
        w_period_count_nxt = r_period_count;
        w_cfg_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (run_en) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                // RUN and STOPPING time the period identically; they differ only
                // in what run_en does mid-period.
                if (w_wrap) begin
                    w_cnt_nxt          = '0;
                    w_period_count_nxt = r_period_count + 16'd1;
                    if (r_pend) begin
                        w_div_a_nxt  = r_div_p;
                        w_high_a_nxt = r_high_p;
                        w_pend_nxt   = 1'b0;
                    end
                    w_state_nxt = run_en ? S_RUN : S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_WIDTH'(1);
                    w_state_nxt = run_en ? S_RUN : S_STOP;
                end
            end
        endcase

        // An accept requires pend clear, so it never collides with the pending
        // transfer above; an accept on a wrap edge lands in pending and waits
        // for the following wrap.
        if (w_cfg_fire) begin
            if (!w_cfg_legal) begin
                w_cfg_err_nxt = 1'b1;
            end else if (r_state == S_IDLE) begin
                w_div_a_nxt  = cfg_div;
                w_high_a_nxt = cfg_high;
            end else begin
                w_div_p_nxt  = cfg_div;
                w_high_p_nxt = cfg_high;
                w_pend_nxt   = 1'b1;
            end
        end

        w_run_nxt     = (w_state_nxt != S_IDLE);
        w_clk_out_nxt = w_run_nxt && (w_cnt_nxt < w_high_a_nxt);
        w_tick_nxt    = w_run_nxt && (w_cnt_nxt == '0);
    end

    always_ff @(posedge FiftyMHz_ref_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_div_a        <= DIV_WIDTH'(DEFAULT_DIV);
            r_high_a       <= DIV_WIDTH'(DEFAULT_HIGH);
            r_div_p        <= '0;
            r_high_p       <= '0;
            r_pend         <= 1'b0;
            r_period_count <= '0;
            r_clk_out      <= 1'b0;
            r_tick         <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_div_a        <= w_div_a_nxt;
            r_high_a       <= w_high_a_nxt;
            r_div_p        <= w_div_p_nxt;
            r_high_p       <= w_high_p_nxt;
            r_pend         <= w_pend_nxt;
            r_period_count <= w_period_count_nxt;
            r_clk_out      <= w_clk_out_nxt;
            r_tick         <= w_tick_nxt;
            r_cfg_err      <= w_cfg_err_nxt;
        end
    end

    assign cfg_ready    = ~r_pend;
    assign cfg_err      = r_cfg_err;
    assign clk_out      = r_clk_out;
    assign tick         = r_tick;
    assign period_count = r_period_count;
    assign running      = (r_state != S_IDLE);

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - self-checking bench for clock_divider_ctrl
module tb_clock_divider_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run_en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic [15:0]  period_count;
    logic         running;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_divider_ctrl #(
        .DIV_WIDTH   (W),
        .DEFAULT_DIV (5),
        .DEFAULT_HIGH(2)
    ) u_dut (
        .FiftyMHz_ref_clock(clk),
        .reset_n           (rst_n),
        .run_en            (run_en),
        .cfg_div           (cfg_div),
        .cfg_high          (cfg_high),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_err           (cfg_err),
        .clk_out           (clk_out),
        .tick              (tick),
        .period_count      (period_count),
        .running           (running)
    );

    // Reference model: a clock is either producing periods or not; each period
    // runs m_div cycles, high for the first m_high; at a period end the block
    // carries on only if run_en is high. Waiting configs live in a queue.
    bit m_active;
    int m_phase;
    int m_div;
    int m_high;
    int m_count;
    bit m_err;
    bit m_hs;
    int pend_div[$];
    int pend_high[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_phase  = 0;
        m_div    = 5;
        m_high   = 2;
        m_count  = 0;
        m_err    = 1'b0;
        m_hs     = 1'b0;
        pend_div.delete();
        pend_high.delete();
    endtask

    task automatic model_step();
        bit hs;
        bit legal;
        bit period_end;
        int d;
        int h;
        d = int'(cfg_div);
        h = int'(cfg_high);
        hs = cfg_valid && (pend_div.size() == 0);
        legal = (d >= 2) && (h >= 1) && (h < d);
        period_end = m_active && (m_phase == m_div - 1);
        m_hs  = hs;
        m_err = hs && !legal;
        if (!m_active) begin
            if (hs && legal) begin
                m_div  = d;
                m_high = h;
            end
            if (run_en) begin
                m_active = 1'b1;
                m_phase  = 0;
            end
        end else begin
            if (period_end) begin
                m_count++;
                m_phase = 0;
                if (pend_div.size() != 0) begin
                    m_div  = pend_div.pop_front();
                    m_high = pend_high.pop_front();
                end
                if (!run_en) m_active = 1'b0;
            end else begin
                m_phase++;
            end
            if (hs && legal) begin
                pend_div.push_back(d);
                pend_high.push_back(h);
            end
        end
    endtask

    task automatic compare_all();
        check("clk_out", 32'(clk_out), 32'(m_active && (m_phase < m_high)));
        check("tick", 32'(tick), 32'(m_active && (m_phase == 0)));
        check("running", 32'(running), 32'(m_active));
        check("period_count", 32'(period_count), 32'(m_count & 32'hFFFF));
        check("cfg_ready", 32'(cfg_ready), 32'(pend_div.size() == 0));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_phase(input int ph);
        bit hit;
        hit = m_active && (m_phase == ph);
        for (int i = 0; i < 64 && !hit; i++) begin
            cycle();
            hit = m_active && (m_phase == ph);
        end
        check("reach_phase", 32'(hit), 32'd1);
    endtask

    task automatic offer(input int d, input int h, input int max_cycles);
        bit got;
        got = 1'b0;
        cfg_div   = W'(d);
        cfg_high  = W'(h);
        cfg_valid = 1'b1;
        for (int i = 0; i < max_cycles && !got; i++) begin
            cycle();
            got = m_hs;
        end
        cfg_valid = 1'b0;
        check("offer_accepted", 32'(got), 32'd1);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_period_count", 32'(period_count), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        run_en = 1'b1;

        // Default 5/2 clock: start edge plus 100 cycles gives 20 completed periods
        cycle();
        run_cycles(100);
        check("pc_after_100", 32'(period_count), 32'd20);

        // Mid-period reconfiguration to 10/5
        run_until_phase(2);
        offer(10, 5, 4);
        run_cycles(30);

        // Illegal offers: dropped with an error pulse
        offer(1, 0, 4);
        run_cycles(8);
        offer(8, 0, 4);
        run_cycles(8);
        offer(4, 4, 4);
        run_cycles(12);

        // Stop requested mid-period, then restart
        run_until_phase(1);
        run_en = 1'b0;
        run_cycles(20);
        check("idle_after_stop", 32'(running), 32'd0);
        run_en = 1'b1;
        run_cycles(6);

        // Accept on a wrap edge, then a second offer stalled behind it
        run_until_phase(m_div - 1);
        offer(6, 3, 2);
        offer(4, 1, 40);
        run_cycles(20);

        // Reset during the high phase with a pending config
        run_until_phase(m_div - 1);
        offer(9, 4, 2);
        check("pre_reset_clk", 32'(clk_out), 32'd1);
        check("pre_reset_pend", 32'(cfg_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_clk_out", 32'(clk_out), 32'd0);
        check("async_running", 32'(running), 32'd0);
        check("async_cfg_ready", 32'(cfg_ready), 32'd1);
        check("async_period_count", 32'(period_count), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        run_cycles(20);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            run_en = ($urandom_range(0, 9) != 0);
            if (!cfg_valid && ($urandom_range(0, 5) == 0)) begin
                cfg_div   = W'($urandom_range(0, 12));
                cfg_high  = W'($urandom_range(0, 12));
                cfg_valid = 1'b1;
            end
            cycle();
            if (m_hs) cfg_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
